// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the I-fetch refill path and the
// D-cache refill/writeback path. Whole-line bursts, round-robin on contention.
module mem_arbiter #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned BEATS  = 4
) (
    input  logic                     CLK,
    input  logic                     CLR,
    input  logic                     i_req,
    input  logic [ADDR_W-1:0]        i_addr,
    output logic                     i_rvalid,
    output logic [WIDTH-1:0]         i_rdata,
    output logic                     i_done,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [ADDR_W-1:0]        d_addr,
    input  logic [WIDTH-1:0]         d_wdata,
    output logic [$clog2(BEATS)-1:0] d_beat,
    output logic                     d_rvalid,
    output logic [WIDTH-1:0]         d_rdata,
    output logic                     d_done,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic [WIDTH-1:0]         mem_rdata,
    input  logic                     mem_ack
);

    localparam int unsigned BW  = $clog2(BEATS);
    localparam int unsigned OFF = BW + 2;
    localparam int unsigned TW  = ADDR_W - OFF;
    localparam logic [BW-1:0] LastBeat = BW'(BEATS - 1);

    typedef enum logic [1:0] {StIdle, StBurst, StDone} stateT;

    stateT         stateQ, stateNext;
    logic          ownerDQ, ownerDNext;   // 1: D owns the port, 0: I owns it
    logic          lastDQ, lastDNext;     // 1: D was granted last
    logic          weQ, weNext;
    logic [BW-1:0] beatQ, beatNext;
    logic [TW-1:0] tagQ, tagNext;         // line address without word/byte offset
    logic          grantD;
    logic          inBurst;

    // Offset bits of the request addresses are don't-care: bursts start at beat 0.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{i_addr[OFF-1:0], d_addr[OFF-1:0]};

    // State registers; reset abandons any burst in flight.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            stateQ  <= StIdle;
            ownerDQ <= 1'b0;
            lastDQ  <= 1'b0;
            weQ     <= 1'b0;
            beatQ   <= '0;
            tagQ    <= '0;
        end else begin
            stateQ  <= stateNext;
            ownerDQ <= ownerDNext;
            lastDQ  <= lastDNext;
            weQ     <= weNext;
            beatQ   <= beatNext;
            tagQ    <= tagNext;
        end
    end

    // Next-state: grant in IDLE, count acked beats in BURST, record last grant in DONE.
    always_comb begin
        stateNext  = stateQ;
        ownerDNext = ownerDQ;
        lastDNext  = lastDQ;
        weNext     = weQ;
        beatNext   = beatQ;
        tagNext    = tagQ;
        // On contention the requester that was not served last wins.
        grantD     = d_req & (~i_req | ~lastDQ);
        unique case (stateQ)
            StIdle: begin
                if (i_req || d_req) begin
                    ownerDNext = grantD;
                    tagNext    = grantD ? d_addr[ADDR_W-1:OFF] : i_addr[ADDR_W-1:OFF];
                    weNext     = grantD & d_we;
                    beatNext   = '0;
                    stateNext  = StBurst;
                end
            end
            StBurst: begin
                if (mem_ack) begin
                    beatNext = beatQ + BW'(1);
                    if (beatQ == LastBeat) begin
                        stateNext = StDone;
                    end
                end
            end
            StDone: begin
                lastDNext = ownerDQ;
                stateNext = StIdle;
            end
            default: stateNext = StIdle;
        endcase
    end

    // Outputs: memory side driven only in BURST; read beats pass straight through.
    always_comb begin
        inBurst   = (stateQ == StBurst);
        mem_req   = inBurst;
        mem_we    = inBurst & ownerDQ & weQ;
        mem_addr  = inBurst ? {tagQ, beatQ, 2'b00} : '0;
        mem_wdata = (inBurst & ownerDQ) ? d_wdata : '0;
        d_beat    = (inBurst & ownerDQ) ? beatQ : '0;
        i_rvalid  = inBurst & ~ownerDQ & mem_ack;
        d_rvalid  = inBurst & ownerDQ & ~weQ & mem_ack;
        i_rdata   = i_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
        i_done    = (stateQ == StDone) & ~ownerDQ;
        d_done    = (stateQ == StDone) & ownerDQ;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a simple memory responder.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata, mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        i_rvalid, i_done, d_rvalid, d_done, mem_req, mem_we;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [1:0]  d_beat;

    int nChecks = 0;
    int nFails  = 0;

    mem_arbiter #(.WIDTH(32), .ADDR_W(32), .BEATS(4)) dut (
        .CLK(CLK), .CLR(CLR),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_beat(d_beat),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 CLK = ~CLK;

    // D cache supplies the write word for the current beat combinationally.
    assign d_wdata = 32'hA0 + 32'(d_beat);

    // Memory responder: ack one cycle after a beat starts; optional stall on beat 2.
    bit stallOn = 1'b0;
    int ackCnt  = 0;
    always @(posedge CLK) begin
        #1;
        if (CLR) begin
            mem_ack = 1'b0;
            ackCnt  = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            ackCnt  = mem_req ? 1 : 0;
        end else if (mem_req) begin
            ackCnt = ackCnt + 1;
            if (ackCnt > ((stallOn && mem_addr[3:2] == 2'd2) ? 6 : 1)) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hD000_0000 ^ mem_addr;
            end
        end
    end

    // Observation record filled by observe()
    logic [31:0] obsAddr [16];
    logic [31:0] obsWd   [16];
    logic [31:0] obsRd   [16];
    bit          obsWe   [16];
    bit          obsOrd  [8];    // 1: D completed, 0: I completed
    int nBeat, nIrv, nDrv, nIdone, nDdone, nOrd, nCyc, dStray, nGlitch;
    bit timedOut;

    // Run until targetDones bursts complete; drop a requester at its done once more
    // than holdDones completions have been seen; drop both after dropAtBeat acks.
    task automatic observe(input int targetDones, input int dropAtBeat, input int holdDones);
        logic        prevPend;
        logic [31:0] prevAddr;
        nBeat = 0; nIrv = 0; nDrv = 0; nIdone = 0; nDdone = 0; nOrd = 0; nCyc = 0;
        dStray = 0; nGlitch = 0; timedOut = 1'b0; prevPend = 1'b0; prevAddr = '0;
        while (nIdone + nDdone < targetDones) begin
            @(negedge CLK);
            nCyc++;
            if (prevPend && (mem_req !== 1'b1 || mem_addr !== prevAddr)) nGlitch++;
            prevPend = mem_req & ~mem_ack;
            prevAddr = mem_addr;
            if (d_rvalid || d_done || d_beat != 0 || d_rdata != 0) dStray++;
            if (mem_ack && mem_req && nBeat < 16) begin
                obsAddr[nBeat] = mem_addr;
                obsWe[nBeat]   = mem_we;
                obsWd[nBeat]   = mem_wdata;
                obsRd[nBeat]   = i_rvalid ? i_rdata : d_rdata;
                nBeat++;
                if (nBeat == dropAtBeat) begin
                    i_req = 1'b0;
                    d_req = 1'b0;
                end
            end
            if (i_rvalid) nIrv++;
            if (d_rvalid) nDrv++;
            if (i_done || d_done) begin
                if (nOrd < 8) obsOrd[nOrd] = d_done;
                nOrd++;
                if (i_done) nIdone++;
                if (d_done) nDdone++;
                if (nIdone + nDdone > holdDones) begin
                    if (i_done) i_req = 1'b0;
                    if (d_done) d_req = 1'b0;
                end
            end
            if (nCyc >= 200) begin
                timedOut = 1'b1;
                i_req = 1'b0;
                d_req = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        CLR = 1'b1;
        repeat (2) @(negedge CLK);
        nChecks++;
        if ({mem_req, mem_we, i_rvalid, i_done, d_rvalid, d_done} !== 6'b0) begin
            nFails++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {mem_req, mem_we, i_rvalid, i_done, d_rvalid, d_done});
        end
        nChecks++;
        if ({mem_addr, mem_wdata, i_rdata, d_rdata, d_beat} !== '0) begin
            nFails++;
            $display("FAIL reset_data: addr %h wdata %h beat %0d", mem_addr, mem_wdata, d_beat);
        end
        CLR = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    int cycI;

    task automatic test_i_read;
        i_addr = 32'h104;
        i_req  = 1'b1;
        observe(1, -1, 0);
        cycI = nCyc;
        nChecks++;
        if (timedOut !== 1'b0 || nBeat !== 4) begin
            nFails++;
            $display("FAIL i_read_beats: got %0d beats timeout %0d want 4", nBeat, timedOut);
        end
        for (int k = 0; k < 4; k++) begin
            nChecks++;
            if (obsAddr[k] !== 32'h100 + 32'(4 * k) || obsRd[k] !== 32'hD000_0100 + 32'(4 * k)
                || obsWe[k] !== 1'b0) begin
                nFails++;
                $display("FAIL i_read_beat%0d: addr %h data %h we %b want %h %h 0", k,
                         obsAddr[k], obsRd[k], obsWe[k], 32'h100 + 32'(4 * k),
                         32'hD000_0100 + 32'(4 * k));
            end
        end
        nChecks++;
        if (nIrv !== 4 || nIdone !== 1 || nDdone !== 0 || dStray !== 0) begin
            nFails++;
            $display("FAIL i_read_pulses: rvalid %0d done %0d ddone %0d dstray %0d want 4 1 0 0",
                     nIrv, nIdone, nDdone, dStray);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_arbitration;
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        repeat (2) @(negedge CLK);
        i_addr = 32'h600; d_addr = 32'h700; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        observe(2, -1, 0);
        nChecks++;
        if (timedOut !== 1'b0 || nOrd !== 2 || obsOrd[0] !== 1'b1 || obsOrd[1] !== 1'b0) begin
            nFails++;
            $display("FAIL arb_first: order %b%b n %0d want D then I", obsOrd[0], obsOrd[1], nOrd);
        end
        nChecks++;
        if (obsAddr[0] !== 32'h700 || obsRd[0] !== 32'hD000_0700 || obsAddr[4] !== 32'h600
            || nDrv !== 4 || nIrv !== 4) begin
            nFails++;
            $display("FAIL arb_steer: a0 %h d0 %h a4 %h drv %0d irv %0d", obsAddr[0], obsRd[0],
                     obsAddr[4], nDrv, nIrv);
        end
        repeat (2) @(negedge CLK);
        d_req = 1'b1;
        observe(1, -1, 0);
        repeat (2) @(negedge CLK);
        i_req = 1'b1; d_req = 1'b1;
        observe(2, -1, 0);
        nChecks++;
        if (timedOut !== 1'b0 || nOrd !== 2 || obsOrd[0] !== 1'b0 || obsOrd[1] !== 1'b1) begin
            nFails++;
            $display("FAIL arb_alternate: order %b%b n %0d want I then D", obsOrd[0], obsOrd[1],
                     nOrd);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_writeback;
        d_addr = 32'h2000; d_we = 1'b1; d_req = 1'b1;
        observe(1, -1, 0);
        nChecks++;
        if (timedOut !== 1'b0 || nBeat !== 4) begin
            nFails++;
            $display("FAIL wb_beats: got %0d want 4", nBeat);
        end
        for (int k = 0; k < 4; k++) begin
            nChecks++;
            if (obsAddr[k] !== 32'h2000 + 32'(4 * k) || obsWd[k] !== 32'hA0 + 32'(k)
                || obsWe[k] !== 1'b1) begin
                nFails++;
                $display("FAIL wb_beat%0d: addr %h wdata %h we %b want %h %h 1", k, obsAddr[k],
                         obsWd[k], obsWe[k], 32'h2000 + 32'(4 * k), 32'hA0 + 32'(k));
            end
        end
        nChecks++;
        if (nDrv !== 0 || nDdone !== 1 || nIdone !== 0) begin
            nFails++;
            $display("FAIL wb_pulses: drv %0d ddone %0d idone %0d want 0 1 0", nDrv, nDdone, nIdone);
        end
        d_we = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_stall;
        stallOn = 1'b1;
        i_addr = 32'h104; i_req = 1'b1;
        observe(1, -1, 0);
        stallOn = 1'b0;
        nChecks++;
        if (timedOut !== 1'b0 || nBeat !== 4 || nIdone !== 1 || obsAddr[2] !== 32'h108
            || obsAddr[3] !== 32'h10C) begin
            nFails++;
            $display("FAIL stall_beats: beats %0d done %0d a2 %h a3 %h", nBeat, nIdone,
                     obsAddr[2], obsAddr[3]);
        end
        nChecks++;
        if (nGlitch !== 0) begin
            nFails++;
            $display("FAIL stall_hold: %0d unstable cycles want 0", nGlitch);
        end
        nChecks++;
        if (nCyc !== cycI + 5) begin
            nFails++;
            $display("FAIL stall_length: %0d cycles want %0d", nCyc, cycI + 5);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_async_reset;
        int acks = 0;
        int budget = 0;
        bit sawDone = 1'b0;
        d_addr = 32'h3000; d_we = 1'b0; d_req = 1'b1;
        while (acks < 2 && budget < 50) begin
            @(negedge CLK);
            budget++;
            if (mem_ack && mem_req) acks++;
        end
        nChecks++;
        if (acks !== 2) begin
            nFails++;
            $display("FAIL areset_setup: %0d acks want 2", acks);
        end
        @(negedge CLK);
        #2 CLR = 1'b1;
        #1;
        nChecks++;
        if ({mem_req, d_rvalid, d_done} !== 3'b0 || mem_addr !== '0 || d_beat !== 2'd0) begin
            nFails++;
            $display("FAIL areset_now: req %b addr %h beat %0d want 0 0 0", mem_req, mem_addr,
                     d_beat);
        end
        repeat (3) begin
            @(negedge CLK);
            if (d_done) sawDone = 1'b1;
        end
        CLR = 1'b0;
        observe(1, -1, 0);
        nChecks++;
        if (sawDone !== 1'b0 || timedOut !== 1'b0 || nBeat !== 4 || obsAddr[0] !== 32'h3000
            || nDdone !== 1) begin
            nFails++;
            $display("FAIL areset_restart: done_in_reset %b beats %0d a0 %h ddone %0d",
                     sawDone, nBeat, obsAddr[0], nDdone);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_req_drop;
        i_addr = 32'h400; i_req = 1'b1;
        observe(1, 1, 0);
        nChecks++;
        if (timedOut !== 1'b0 || nBeat !== 4 || nIdone !== 1 || obsAddr[3] !== 32'h40C) begin
            nFails++;
            $display("FAIL drop_completes: beats %0d done %0d a3 %h want 4 1 40c", nBeat,
                     nIdone, obsAddr[3]);
        end
        repeat (2) @(negedge CLK);
        i_addr = 32'h500; i_req = 1'b1;
        observe(2, -1, 1);
        nChecks++;
        if (timedOut !== 1'b0 || nBeat !== 8 || nIdone !== 2 || obsAddr[4] !== 32'h500
            || obsAddr[7] !== 32'h50C) begin
            nFails++;
            $display("FAIL back_to_back: beats %0d done %0d a4 %h a7 %h want 8 2 500 50c",
                     nBeat, nIdone, obsAddr[4], obsAddr[7]);
        end
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_arbitration();
        test_writeback();
        test_stall();
        test_async_reset();
        test_req_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
